// File: rtl/inst_loader.sv
// ---------------------------------------------------------------------------
// inst_loader
// Byte-stream boot loader. It receives a framed program image from a serial
// receiver, assembles 32-bit instruction words and writes them into
// instruction memory while holding the CPU in reset.
//
// Frame: HEADER, N, N x (4 bytes, MSB first), checksum (XOR of N and data).
//
// Ports
//   ClkIn       in   1   clock, rising edge
//   Reset       in   1   synchronous, active-high
//   RxValid     in   1   strobe: RxByte holds a received byte
//   RxByte      in   8   received byte
//   MemWE       out  1   one-cycle instruction-memory write strobe
//   MemAddr     out  32  word-aligned byte address of the write
//   MemWData    out  32  instruction word to write
//   CpuHold     out  1   processor held in reset while high
//   Done        out  1   last load completed with a good checksum
//   Error       out  1   last load aborted (bad checksum or timeout)
//   WordsLoaded out  8   words written in the current or last load
// ---------------------------------------------------------------------------
module inst_loader #(
  parameter logic [7:0] HEADER  = 8'hA5,
  parameter int         TIMEOUT = 1000000
) (
  input  logic        ClkIn,
  input  logic        Reset,
  input  logic        RxValid,
  input  logic [7:0]  RxByte,
  output logic        MemWE,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic        CpuHold,
  output logic        Done,
  output logic        Error,
  output logic [7:0]  WordsLoaded
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, COUNT, DATA, CHECK, DONE, ERR} state_t;

  state_t        state, state_nx;
  logic [7:0]    n_words;
  logic [7:0]    words_asm;     // index of the word currently being assembled
  logic [7:0]    csum;
  logic [7:0]    words_loaded;
  logic [1:0]    byte_cnt;
  logic [23:0]   asm_sr;        // first three bytes of the word in flight
  logic [TW-1:0] tmo_cnt;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;

  logic active;
  logic is_header;
  logic tmo_hit;
  logic last_byte;

  assign active    = (state == COUNT) || (state == DATA) || (state == CHECK);
  assign is_header = RxValid && (RxByte == HEADER);
  assign tmo_hit   = active && !RxValid && (tmo_cnt == TW'(TIMEOUT - 1));
  assign last_byte = RxValid && (state == DATA) && (byte_cnt == 2'd3) &&
                     (words_asm == n_words - 8'd1);

  // State register
  always_ff @(posedge ClkIn) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (is_header) state_nx = COUNT;
      COUNT: begin
        if (RxValid)      state_nx = (RxByte == 8'd0) ? CHECK : DATA;
        else if (tmo_hit) state_nx = ERR;
      end
      // Leaving DATA on the last byte lets a checksum byte arriving in the
      // write cycle be taken by CHECK without being dropped.
      DATA: begin
        if (last_byte)    state_nx = CHECK;
        else if (tmo_hit) state_nx = ERR;
      end
      CHECK: begin
        if (RxValid)      state_nx = (RxByte == csum) ? DONE : ERR;
        else if (tmo_hit) state_nx = ERR;
      end
      DONE, ERR: if (is_header) state_nx = COUNT;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: checksum, word assembly, write staging, counters
  always_ff @(posedge ClkIn) begin
    if (Reset) begin
      n_words      <= '0;
      words_asm    <= '0;
      csum         <= '0;
      words_loaded <= '0;
      byte_cnt     <= '0;
      asm_sr       <= '0;
      tmo_cnt      <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      we_q <= 1'b0;
      if (we_q) words_loaded <= words_loaded + 8'd1;

      if (!active || RxValid || tmo_hit) tmo_cnt <= '0;
      else                               tmo_cnt <= tmo_cnt + 1'b1;

      case (state)
        IDLE, DONE, ERR: begin
          if (is_header) begin
            words_loaded <= '0;
            words_asm    <= '0;
            csum         <= '0;
            byte_cnt     <= '0;
          end
        end
        COUNT: begin
          if (RxValid) begin
            n_words <= RxByte;
            csum    <= RxByte;
          end
        end
        DATA: begin
          if (RxValid) begin
            csum     <= csum ^ RxByte;
            byte_cnt <= byte_cnt + 2'd1;
            asm_sr   <= {asm_sr[15:0], RxByte};
            if (byte_cnt == 2'd3) begin
              we_q      <= 1'b1;
              addr_q    <= {22'd0, words_asm, 2'b00};
              wdata_q   <= {asm_sr, RxByte};
              words_asm <= words_asm + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    CpuHold     = active || (state == ERR);
    Done        = (state == DONE);
    Error       = (state == ERR);
    MemWE       = we_q;
    MemAddr     = addr_q;
    MemWData    = wdata_q;
    WordsLoaded = words_loaded;
  end

endmodule

// File: tb/tb_inst_loader.sv
// ---------------------------------------------------------------------------
// tb_inst_loader
// Self-checking bench for inst_loader. Expected memory writes are queued as
// frames are sent; a monitor pops and compares on every MemWE. Status
// outputs are checked directly after each frame.
// ---------------------------------------------------------------------------
module tb_inst_loader;

  logic        ClkIn = 1'b0;
  logic        Reset = 1'b0;
  logic        RxValid = 1'b0;
  logic [7:0]  RxByte = 8'h00;
  logic        MemWE;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic        CpuHold;
  logic        Done;
  logic        Error;
  logic [7:0]  WordsLoaded;

  int tests = 0;
  int fails = 0;

  logic [63:0] exp_q[$];   // {addr, data}

  inst_loader #(.HEADER(8'hA5), .TIMEOUT(16)) dut (
    .ClkIn(ClkIn), .Reset(Reset), .RxValid(RxValid), .RxByte(RxByte),
    .MemWE(MemWE), .MemAddr(MemAddr), .MemWData(MemWData),
    .CpuHold(CpuHold), .Done(Done), .Error(Error), .WordsLoaded(WordsLoaded)
  );

  always #5 ClkIn = ~ClkIn;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the head of the expected queue.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge ClkIn);
      if (MemWE === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write", MemAddr, MemWData);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", MemAddr, e[63:32]);
          chk("write_data", MemWData, e[31:0]);
        end
      end
    end
  end

  // One byte per clock; consecutive calls give back-to-back RxValid.
  task automatic send(input logic [7:0] b);
    @(negedge ClkIn);
    RxValid = 1'b1;
    RxByte  = b;
    @(posedge ClkIn);
    #1;
    RxValid = 1'b0;
  endtask

  task automatic send_list(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send(bytes[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge ClkIn);
    #1;
  endtask

  task automatic do_reset();
    @(negedge ClkIn);
    Reset = 1'b1;
    @(negedge ClkIn);
    Reset = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic d, input logic e,
                            input logic h, input logic [7:0] w);
    chk({tag, "_done"},  {31'd0, Done},    {31'd0, d});
    chk({tag, "_error"}, {31'd0, Error},   {31'd0, e});
    chk({tag, "_hold"},  {31'd0, CpuHold}, {31'd0, h});
    chk({tag, "_words"}, {24'd0, WordsLoaded}, {24'd0, w});
  endtask

  task automatic chk_drained(input string tag);
    chk({tag, "_pending_writes"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_we",    {31'd0, MemWE}, 32'd0);
    chk("rst_addr",  MemAddr, 32'd0);
    chk("rst_wdata", MemWData, 32'd0);
    chk_status("rst", 1'b0, 1'b0, 1'b0, 8'd0);

    // Two-word frame, checksum 02
    exp_q.push_back({32'd0, 32'h00112233});
    exp_q.push_back({32'd4, 32'h44556677});
    send_list('{8'hA5, 8'h02});
    chk("two_mid_hold", {31'd0, CpuHold}, 32'd1);
    send_list('{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h02});
    idle(3);
    chk_status("two", 1'b1, 1'b0, 1'b0, 8'd2);
    chk_drained("two");

    // Bad checksum (correct would be 23)
    exp_q.push_back({32'd0, 32'hDEADBEEF});
    send_list('{8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00});
    idle(3);
    chk_status("badcs", 1'b0, 1'b1, 1'b1, 8'd1);
    chk_drained("badcs");

    // Empty frame restarts out of ERR
    send_list('{8'hA5, 8'h00, 8'h00});
    idle(3);
    chk_status("empty", 1'b1, 1'b0, 1'b0, 8'd0);

    // Timeout after a partial word: ERR exactly on the 16th idle edge
    send_list('{8'hA5, 8'h01, 8'h12});
    idle(15);
    chk_status("tmo_before", 1'b0, 1'b0, 1'b1, 8'd0);
    idle(1);
    chk_status("tmo_at", 1'b0, 1'b1, 1'b1, 8'd0);
    idle(4);
    chk("tmo_stays_err", {31'd0, Error}, 32'd1);

    // Reset mid-load, then a full one-word frame (checksum 31)
    send_list('{8'hA5, 8'h01, 8'hAA, 8'hBB});
    do_reset();
    idle(2);
    chk_status("midrst", 1'b0, 1'b0, 1'b0, 8'd0);
    exp_q.push_back({32'd0, 32'hCAFEBABE});
    send_list('{8'hA5, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h31});
    idle(3);
    chk_status("after_rst", 1'b1, 1'b0, 1'b0, 8'd1);
    chk_drained("after_rst");

    // Leading junk in IDLE, continuous stream, HEADER-valued data bytes,
    // checksum byte landing in the write cycle (checksum 05)
    do_reset();
    exp_q.push_back({32'd0, 32'hA5010203});
    exp_q.push_back({32'd4, 32'h040506A5});
    send_list('{8'h00, 8'hFF, 8'hA5, 8'h02, 8'hA5, 8'h01, 8'h02, 8'h03,
                8'h04, 8'h05, 8'h06, 8'hA5, 8'h05});
    idle(3);
    chk_status("stream", 1'b1, 1'b0, 1'b0, 8'd2);
    chk_drained("stream");

    // Non-HEADER byte in DONE is ignored
    send(8'h33);
    idle(3);
    chk_status("done_junk", 1'b1, 1'b0, 1'b0, 8'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter HEADER, default 8'hA5, is the load-start marker byte.
REQ-002 Parameter TIMEOUT, default 1000000, is the maximum ClkIn cycles allowed between accepted bytes during a load.
REQ-003 ClkIn  input  1  single clock for all state; rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 RxValid  input  1  one-cycle strobe: RxByte holds a received byte.
REQ-006 RxByte  input  8  received byte from the serial receiver.
REQ-007 MemWE  output  1  one-cycle instruction-memory write strobe.
REQ-008 MemAddr  output  32  byte address of the write, always word-aligned.
REQ-009 MemWData  output  32  instruction word to write.
REQ-010 CpuHold  output  1  holds the processor in reset while high.
REQ-011 Done  output  1  level: last load completed with a good checksum.
REQ-012 Error  output  1  level: last load aborted (checksum mismatch or timeout).
REQ-013 WordsLoaded  output  8  count of words written in the current or last load.

Function
REQ-014 Frame format, in order: HEADER, word count N (0-255), N words of 4 bytes each (most-significant byte first), then one checksum byte.
REQ-015 The checksum is the XOR of the N byte and all 4N data bytes.
REQ-016 States: IDLE, COUNT, DATA, CHECK, DONE, ERR.
REQ-017 IDLE: an accepted byte equal to HEADER moves to COUNT; any other byte is ignored.
REQ-018 COUNT: the accepted byte is latched as N; N=0 moves to CHECK, otherwise to DATA.
REQ-019 DATA: accepted bytes shift into a 32-bit assembly register, MSB first, and a 2-bit byte counter advances.
REQ-020 DATA: the cycle after the 4th byte of a word is accepted, MemWE=1 for exactly one cycle with MemAddr=4*WordsLoaded and MemWData=the assembled word; WordsLoaded then increments.
REQ-021 DATA: after the write of word N, the state moves to CHECK.
REQ-022 Back-to-back RxValid on consecutive cycles is legal; no byte is dropped, including a byte arriving in the same cycle as MemWE.
REQ-023 CHECK: the accepted byte is compared with the running XOR; a match moves to DONE, a mismatch moves to ERR.
REQ-024 CpuHold=1 in COUNT, DATA, CHECK and ERR; CpuHold=0 in IDLE and DONE.
REQ-025 DONE: Done=1, Error=0.
REQ-026 ERR: Error=1, Done=0.
REQ-027 In DONE or ERR, an accepted HEADER byte starts a new load: go to COUNT, clear Done, Error, WordsLoaded and the checksum.
REQ-028 In DONE or ERR, all non-HEADER bytes are ignored.
REQ-029 A timeout counter clears on every accepted byte and counts in COUNT, DATA and CHECK.
REQ-030 When the timeout counter reaches TIMEOUT, the state moves to ERR and no write for a partial word is issued.
REQ-031 A HEADER-valued byte received in COUNT, DATA or CHECK is treated as data, not as a restart.
REQ-032 WordsLoaded saturates at N; MemAddr never exceeds 4*(N-1).
REQ-033 MemWE=0 in every state except the single write cycle defined in REQ-020.

Reset
REQ-034 Reset=1 at a rising ClkIn edge forces IDLE and clears MemWE, MemAddr, MemWData, CpuHold, Done, Error, WordsLoaded, the checksum and the timeout counter to 0.
REQ-035 Reset mid-load aborts the load with no further MemWE; instruction-memory words already written are not undone.
REQ-036 Reset takes priority over RxValid in the same cycle.

Verification
REQ-037 Send A5,02,00,11,22,33,44,55,66,77,(02^00^11^22^33^44^55^66^77) -> two writes: 0x00112233 at address 0, then 0x44556677 at address 4; then Done=1, CpuHold=0, WordsLoaded=2.
REQ-038 Send A5,01,DE,AD,BE,EF with a wrong checksum byte -> one write of 0xDEADBEEF at address 0; then Error=1, CpuHold=1.
REQ-039 Send A5,00,00 -> no MemWE; Done=1.
REQ-040 Send A5,01,12 then no further bytes for TIMEOUT cycles (TIMEOUT=16 in the bench) -> ERR, Error=1, no MemWE.
REQ-041 Assert Reset after the 2nd data byte, then send a full 1-word frame -> the first frame produces no write; the second frame writes at address 0 and ends with Done=1.
REQ-042 Send bytes 00,FF,A5 in IDLE, then a valid frame with RxValid high every cycle -> leading junk ignored; all words written with no bytes dropped.
